riscv_exec_unit: RTL
====================

RISCV_EXEC_UNIT -- requirements
Module: riscv_exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter: SHW, default $clog2(XLEN), shift-amount width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit can accept request this cycle.
REQ-007 operand1  input  XLEN  rs1 value.
REQ-008 operand2  input  XLEN  rs2 value or sign-extended immediate.
REQ-009 opcode  input  7  instruction opcode.
REQ-010 funct3  input  3  instruction funct3.
REQ-011 funct7  input  7  instruction funct7.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  registered ALU result.
REQ-015 zero  output  1  branch-taken flag (branch opcode only, else 0).
REQ-016 illegal  output  1  request was not a supported operation.

Function
REQ-017 FSM states: IDLE, BUSY (multiply iterating), HOLD (out_valid=1).
REQ-018 Transfer in on in_valid&&in_ready; in_ready = (IDLE) || (HOLD && out_ready).
REQ-019 Non-multiply request: result/zero/illegal registered at accept edge; state -> HOLD; latency 1 cycle.
REQ-020 HOLD: outputs held stable until out_ready; on out_ready with no new accept -> IDLE; with new accept, next result loaded same edge (back-to-back, 1 op/cycle).
REQ-021 opcode 0110011 funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND; funct7 0100000: 000 SUB, 101 SRA; other funct7/funct3 combos illegal.
REQ-022 opcode 0010011: ADDI/SLTI/SLTIU/XORI/ORI/ANDI per funct3; 001 SLLI requires funct7 0000000; 101 SRLI (funct7 0000000) / SRAI (funct7 0100000); else illegal.
REQ-023 Shift amount = operand2[SHW-1:0]; upper bits ignored.
REQ-024 Add/sub wrap modulo 2^XLEN; SLT signed, SLTU unsigned, result 0 or 1.
REQ-025 opcode 1100011: zero = taken for BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; funct3 010/011 illegal; result = 0.
REQ-026 Illegal request: result 0, zero 0, illegal 1, still completes with latency 1.
REQ-027 in_valid while in_ready=0 is not consumed; requester holds it.

Reset
REQ-028 rst_n low: state IDLE, out_valid 0, result 0, zero 0, illegal 0, multiply counters/accumulator 0; in_ready 1 from first edge after release.
REQ-029 Reset during BUSY or HOLD discards the operation; no output produced.

Configuration
REQ-030 Macro RISCV_EXEC_MUL_EN defined: opcode 0110011 funct7 0000001 funct3 000 (MUL) accepted; shift-add, one bit per cycle, XLEN cycles in BUSY then HOLD; latency XLEN+1; result = low XLEN bits of product; in_ready 0 during BUSY; other funct3 with funct7 0000001 illegal.
REQ-031 Macro undefined: any funct7 0000001 request is illegal (latency 1); BUSY state and multiply datapath absent.

Structure
REQ-032 Shared package riscv_exec_pkg: opcode constants (OP, OP_IMM, BRANCH), funct3/funct7 constants, FSM state typedef.
REQ-033 Sub-module riscv_exec_mul (iterative multiplier, start/done handshake), instantiated only under RISCV_EXEC_MUL_EN.

Verification
REQ-034 XLEN=32, OP SUB op1=5 op2=7, out_ready=1 -> next cycle out_valid=1, result=0xFFFFFFFE, illegal=0.
REQ-035 OP_IMM SRAI op1=0x80000000 op2=0x404 -> result=0xF8000000; SRLI same operands -> 0x08000000.
REQ-036 BRANCH BLT op1=0xFFFFFFFF op2=1 -> zero=1; BLTU same -> zero=0; funct3 010 -> illegal=1, zero=0.
REQ-037 out_ready=0 for 3 cycles after result -> result stable, in_ready=0; then out_ready=1 with queued ADD 2+3 -> next result 5 without bubble.
REQ-038 MUL_EN: MUL 0x10000 x 0x10001 -> result 0x00010000 after 33 cycles; without macro -> illegal=1 after 1 cycle.
REQ-039 rst_n asserted mid-BUSY -> out_valid 0 immediately, in_ready 1 after release, no stale result.

Source files
------------

// File: rtl/riscv_exec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : riscv_exec_pkg                                                   |
// | Brief  : Shared opcode/funct constants and FSM state type for the RV      |
// |          execution unit; BUSY exists only when RISCV_EXEC_MUL_EN is set.  |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
package riscv_exec_pkg;

    localparam logic [6:0] OP           = 7'b0110011;
    localparam logic [6:0] OP_IMM       = 7'b0010011;
    localparam logic [6:0] BRANCH       = 7'b1100011;

    localparam logic [6:0] c_f7_base    = 7'b0000000;
    localparam logic [6:0] c_f7_alt     = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv  = 7'b0000001;

    localparam logic [2:0] c_f3_add     = 3'b000;
    localparam logic [2:0] c_f3_sll     = 3'b001;
    localparam logic [2:0] c_f3_slt     = 3'b010;
    localparam logic [2:0] c_f3_sltu    = 3'b011;
    localparam logic [2:0] c_f3_xor     = 3'b100;
    localparam logic [2:0] c_f3_sr      = 3'b101;
    localparam logic [2:0] c_f3_or      = 3'b110;
    localparam logic [2:0] c_f3_and     = 3'b111;

    localparam logic [2:0] c_f3_beq     = 3'b000;
    localparam logic [2:0] c_f3_bne     = 3'b001;
    localparam logic [2:0] c_f3_blt     = 3'b100;
    localparam logic [2:0] c_f3_bge     = 3'b101;
    localparam logic [2:0] c_f3_bltu    = 3'b110;
    localparam logic [2:0] c_f3_bgeu    = 3'b111;

`ifdef RISCV_EXEC_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10
    } exec_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b10
    } exec_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/riscv_exec_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : riscv_exec_mul                                                   |
// | Brief  : Iterative shift-add multiplier, one multiplier bit per cycle,    |
// |          used by riscv_exec_unit only when RISCV_EXEC_MUL_EN is defined.  |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
module riscv_exec_mul #(
    parameter  int XLEN = 32,
    localparam int CNTW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_multiplicand,
    input  logic [XLEN-1:0] i_multiplier,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);

    localparam logic [CNTW-1:0] c_last = CNTW'(XLEN - 1);

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [CNTW-1:0] r_count;
    logic            r_busy;
    logic [XLEN-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Product is presented combinationally on the final step so the caller
    // can register it on the same edge that would retire the last bit.
    assign o_done    = r_busy && (r_count == c_last);
    assign o_product = w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : riscv_exec_unit                                                  |
// | Brief  : RV32/64 integer ALU + branch compare with valid/ready handshake; |
// |          RISCV_EXEC_MUL_EN adds an iterative MUL through riscv_exec_mul.  |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
module riscv_exec_unit
    import riscv_exec_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    exec_state_t     r_state;
    exec_state_t     w_next_state;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    logic            w_accept;
    logic            w_load;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_sll;
    logic [XLEN-1:0] w_srl;
    logic [XLEN-1:0] w_sra;
    logic            w_eq;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] w_slt_word;
    logic [XLEN-1:0] w_sltu_word;
    logic [XLEN-1:0] w_alu_result;
    logic            w_alu_zero;
    logic            w_alu_illegal;

`ifdef RISCV_EXEC_MUL_EN
    logic            w_is_mul;
    logic            w_mul_start;
    logic            w_mul_done;
    logic [XLEN-1:0] w_mul_product;
`endif

    assign w_shamt     = operand2[SHW-1:0];
    assign w_sum       = operand1 + operand2;
    assign w_diff      = operand1 - operand2;
    assign w_sll       = operand1 << w_shamt;
    assign w_srl       = operand1 >> w_shamt;
    assign w_sra       = $signed(operand1) >>> w_shamt;
    assign w_eq        = (operand1 == operand2);
    assign w_slt       = ($signed(operand1) < $signed(operand2));
    assign w_sltu      = (operand1 < operand2);
    assign w_slt_word  = {{(XLEN-1){1'b0}}, w_slt};
    assign w_sltu_word = {{(XLEN-1){1'b0}}, w_sltu};

    // Illegal requests leave result/zero at their zero defaults.
    always_comb begin
        w_alu_result  = '0;
        w_alu_zero    = 1'b0;
        w_alu_illegal = 1'b0;
`ifdef RISCV_EXEC_MUL_EN
        w_is_mul      = 1'b0;
`endif
        case (opcode)
            OP: begin
                if (funct7 == c_f7_base) begin
                    case (funct3)
                        c_f3_add:  w_alu_result = w_sum;
                        c_f3_sll:  w_alu_result = w_sll;
                        c_f3_slt:  w_alu_result = w_slt_word;
                        c_f3_sltu: w_alu_result = w_sltu_word;
                        c_f3_xor:  w_alu_result = operand1 ^ operand2;
                        c_f3_sr:   w_alu_result = w_srl;
                        c_f3_or:   w_alu_result = operand1 | operand2;
                        default:   w_alu_result = operand1 & operand2;
                    endcase
                end else if ((funct7 == c_f7_alt) && (funct3 == c_f3_add)) begin
                    w_alu_result = w_diff;
                end else if ((funct7 == c_f7_alt) && (funct3 == c_f3_sr)) begin
                    w_alu_result = w_sra;
`ifdef RISCV_EXEC_MUL_EN
                end else if ((funct7 == c_f7_muldiv) && (funct3 == c_f3_add)) begin
                    w_is_mul = 1'b1;
`endif
                end else begin
                    w_alu_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                case (funct3)
                    c_f3_add:  w_alu_result = w_sum;
                    c_f3_slt:  w_alu_result = w_slt_word;
                    c_f3_sltu: w_alu_result = w_sltu_word;
                    c_f3_xor:  w_alu_result = operand1 ^ operand2;
                    c_f3_or:   w_alu_result = operand1 | operand2;
                    c_f3_and:  w_alu_result = operand1 & operand2;
                    c_f3_sll: begin
                        if (funct7 == c_f7_base) w_alu_result = w_sll;
                        else                     w_alu_illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == c_f7_base)     w_alu_result = w_srl;
                        else if (funct7 == c_f7_alt) w_alu_result = w_sra;
                        else                         w_alu_illegal = 1'b1;
                    end
                endcase
            end
            BRANCH: begin
                case (funct3)
                    c_f3_beq:  w_alu_zero = w_eq;
                    c_f3_bne:  w_alu_zero = !w_eq;
                    c_f3_blt:  w_alu_zero = w_slt;
                    c_f3_bge:  w_alu_zero = !w_slt;
                    c_f3_bltu: w_alu_zero = w_sltu;
                    c_f3_bgeu: w_alu_zero = !w_sltu;
                    default:   w_alu_illegal = 1'b1;
                endcase
            end
            default: w_alu_illegal = 1'b1;
        endcase
    end

    assign out_valid = (r_state == HOLD);
    assign in_ready  = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
`ifdef RISCV_EXEC_MUL_EN
        w_mul_start  = 1'b0;
`endif
        case (r_state)
            IDLE, HOLD: begin
                if (w_accept) begin
                    w_next_state = HOLD;
                    w_load       = 1'b1;
`ifdef RISCV_EXEC_MUL_EN
                    if (w_is_mul) begin
                        w_next_state = BUSY;
                        w_load       = 1'b0;
                        w_mul_start  = 1'b1;
                    end
`endif
                end else if ((r_state == HOLD) && out_ready) begin
                    w_next_state = IDLE;
                end
            end
`ifdef RISCV_EXEC_MUL_EN
            BUSY: begin
                if (w_mul_done) w_next_state = HOLD;
            end
`endif
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_result  <= w_alu_result;
                r_zero    <= w_alu_zero;
                r_illegal <= w_alu_illegal;
`ifdef RISCV_EXEC_MUL_EN
            end else if ((r_state == BUSY) && w_mul_done) begin
                r_result  <= w_mul_product;
                r_zero    <= 1'b0;
                r_illegal <= 1'b0;
`endif
            end
        end
    end

`ifdef RISCV_EXEC_MUL_EN
    riscv_exec_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_mul_start),
        .i_multiplicand (operand1),
        .i_multiplier   (operand2),
        .o_done         (w_mul_done),
        .o_product      (w_mul_product)
    );
`endif

endmodule
`default_nettype wire
